// File: rtl/fg_dac_write_sequencer.sv
// DAC write sequencer: registers each sample onto the parallel DAC bus and paces the WR strobe
// through setup, write and settle phases. Optional overwrite counter: FG_DAC_OVERRUN_CNT_EN.
module fg_dac_write_sequencer #(
   parameter int BITWIDTH      = 8,
   parameter int SETUP_CYCLES  = 1,
   parameter int WR_CYCLES     = 2,
   parameter int SETTLE_CYCLES = 500,
   parameter int CNT_BITWIDTH  = 10
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                enable_i,
   input  logic [BITWIDTH-1:0] sample_i,
   input  logic                sampleValid_STRB_i,
   input  logic                clrOverrun_i,
   output logic [BITWIDTH-1:0] dac_data_o,
   output logic                dac_wr_n_o,
   output logic                dac_clr_n_o,
   output logic                dac_pd_n_o,
   output logic                busy_o,
`ifdef FG_DAC_OVERRUN_CNT_EN
   output logic                overrun_o,
   output logic [7:0]          overrunCnt_o
`else
   output logic                overrun_o
`endif
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] WRITE  = 2'd2;
   localparam logic [1:0] SETTLE = 2'd3;

   localparam logic [CNT_BITWIDTH-1:0] SETUP_LD  = CNT_BITWIDTH'(SETUP_CYCLES - 1);
   localparam logic [CNT_BITWIDTH-1:0] WR_LD     = CNT_BITWIDTH'(WR_CYCLES - 1);
   localparam logic [CNT_BITWIDTH-1:0] SETTLE_LD = CNT_BITWIDTH'(SETTLE_CYCLES - 1);

   logic [1:0]              r_state;
   logic [CNT_BITWIDTH-1:0] r_cnt;
   logic [BITWIDTH-1:0]     r_data;
   logic                    r_wr_n;
   logic                    r_clr_n;
   logic                    r_pd_n;
   logic [BITWIDTH-1:0]     r_pend;
   logic                    r_pend_vld;
   logic                    r_overrun;

   logic w_cnt_zero;
   logic w_consume;
   logic w_strb_to_pend;
   logic w_ovr;

   assign w_cnt_zero = (r_cnt == '0);
   // Pending is drained at the end of settle; the IDLE term only covers a sample that was
   // parked on the very edge the settle phase ended with nothing pending.
   assign w_consume      = enable_i & r_pend_vld &
                           (((r_state == SETTLE) & w_cnt_zero) | (r_state == IDLE));
   assign w_strb_to_pend = enable_i & sampleValid_STRB_i & ((r_state != IDLE) | r_pend_vld);
   assign w_ovr          = w_strb_to_pend & r_pend_vld & ~w_consume;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_data     <= '0;
         r_wr_n     <= 1'b1;
         r_clr_n    <= 1'b0;
         r_pd_n     <= 1'b0;
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_clr_n <= 1'b1;
         r_pd_n  <= enable_i;
         case (r_state)
            IDLE: begin
               if (w_consume) begin
                  r_data  <= r_pend;
                  r_cnt   <= SETUP_LD;
                  r_state <= SETUP;
               end else if (sampleValid_STRB_i && enable_i) begin
                  r_data  <= sample_i;
                  r_cnt   <= SETUP_LD;
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
               else begin
                  r_wr_n  <= 1'b0;
                  r_cnt   <= WR_LD;
                  r_state <= WRITE;
               end
            end
            WRITE: begin
               if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
               else begin
                  r_wr_n  <= 1'b1;
                  r_cnt   <= SETTLE_LD;
                  r_state <= SETTLE;
               end
            end
            default: begin
               if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
               else if (w_consume) begin
                  r_data  <= r_pend;
                  r_cnt   <= SETUP_LD;
                  r_state <= SETUP;
               end else r_state <= IDLE;
            end
         endcase

         if (!enable_i) r_pend_vld <= 1'b0;
         else if (w_strb_to_pend) begin
            r_pend     <= sample_i;
            r_pend_vld <= 1'b1;
         end else if (w_consume) r_pend_vld <= 1'b0;

         if (w_ovr) r_overrun <= 1'b1;
         else if (clrOverrun_i) r_overrun <= 1'b0;
      end
   end

`ifdef FG_DAC_OVERRUN_CNT_EN
   logic [7:0] r_ovr_cnt;
   always_ff @(posedge clk_i) begin
      if (rst_i) r_ovr_cnt <= '0;
      else if (w_ovr) begin
         if (r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 1'b1;
      end else if (clrOverrun_i) r_ovr_cnt <= '0;
   end
   assign overrunCnt_o = r_ovr_cnt;
`endif

   assign dac_data_o  = r_data;
   assign dac_wr_n_o  = r_wr_n;
   assign dac_clr_n_o = r_clr_n;
   assign dac_pd_n_o  = r_pd_n;
   assign busy_o      = (r_state != IDLE);
   assign overrun_o   = r_overrun;

endmodule
